// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port memory between two requesters.
// Each transaction runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP, and every output is registered.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0] state_reg;
  logic [3:0] cnt_reg;
  logic       last_grant_reg;
  logic       we_reg;

  logic grant_valid;
  logic grant_idx;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) grant_idx = ~last_grant_reg;
    else              grant_idx = req1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      last_grant_reg <= 1'b1;
      we_reg         <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata          <= '0;
      sel            <= 1'b0;
      busy           <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            sel            <= grant_idx;
            last_grant_reg <= grant_idx;
            mem_addr       <= grant_idx ? addr1 : addr0;
            mem_wdata      <= grant_idx ? wdata1 : wdata0;
            we_reg         <= grant_idx ? we1 : we0;
            // Strobes are set here so they are visible during the ISSUE cycle.
            mem_en         <= 1'b1;
            mem_we         <= grant_idx ? we1 : we0;
            busy           <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          cnt_reg   <= LAT_M1;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            if (!we_reg) rdata <= mem_rdata;
            ack0      <= ~sel;
            ack1      <= sel;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance driven from a cycle table and
// hand-written sequences, plus a MEM_LAT=3 instance for the long-latency and address-hold case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, sel, busy, mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT = 3 instance
  logic        req0_b, we0_b, req1_b, we1_b;
  logic [31:0] addr0_b, wdata0_b, addr1_b, wdata1_b;
  logic        ack0_b, ack1_b, sel_b, busy_b, mem_en_b, mem_we_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .sel(sel), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b),
    .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .sel(sel_b), .busy(busy_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Memory models: registered read that holds its value; unwritten words have fixed contents.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   init_word = 32'hDEADBEEF;
      8'h99:   init_word = 32'h12345678;
      default: init_word = {24'h0, a};
    endcase
  endfunction

  logic [31:0] mem_a [256];
  bit          wr_a  [256];
  logic [31:0] rd_a = 32'h0;
  logic [31:0] mem_b [256];
  bit          wr_b  [256];
  logic [31:0] rd_b = 32'h0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_a[mem_addr[7:0]] <= mem_wdata;
        wr_a[mem_addr[7:0]]  <= 1'b1;
      end else begin
        rd_a <= wr_a[mem_addr[7:0]] ? mem_a[mem_addr[7:0]] : init_word(mem_addr[7:0]);
      end
    end
    if (mem_en_b) begin
      if (mem_we_b) begin
        mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
        wr_b[mem_addr_b[7:0]]  <= 1'b1;
      end else begin
        rd_b <= wr_b[mem_addr_b[7:0]] ? mem_b[mem_addr_b[7:0]] : init_word(mem_addr_b[7:0]);
      end
    end
  end
  assign mem_rdata   = rd_a;
  assign mem_rdata_b = rd_b;

  typedef struct packed {
    logic        ack0, ack1, sel, busy, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, rdata;
  } outs_t;

  typedef struct packed {
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
  } ins_t;

  typedef struct {
    ins_t  i;
    outs_t e;
  } vec_t;

  function automatic ins_t inp(input logic r0, w0, input logic [31:0] a0, d0,
                               input logic r1, w1, input logic [31:0] a1, d1);
    inp = {r0, w0, a0, d0, r1, w1, a1, d1};
  endfunction

  function automatic outs_t ex(input logic a0, a1, s, b, e, w,
                               input logic [31:0] ma, md, rd);
    ex = {a0, a1, s, b, e, w, ma, md, rd};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic outs_t cur1();
    cur1 = {ack0, ack1, sel, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata};
  endfunction

  function automatic outs_t cur3();
    cur3 = {ack0_b, ack1_b, sel_b, busy_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, rdata_b};
  endfunction

  task automatic clear_inputs();
    {req0, we0, addr0, wdata0, req1, we1, addr1, wdata1} = '0;
    {req0_b, we0_b, addr0_b, wdata0_b, req1_b, we1_b, addr1_b, wdata1_b} = '0;
  endtask

  // Leaves the caller at a falling edge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset_dut1", 128'(cur1()), 128'(outs_t'(0)));
    check("reset_dut3", 128'(cur3()), 128'(outs_t'(0)));
    rst = 1'b0;
  endtask

  vec_t vec [9];

  initial begin
    // Single read on requester 0, then a write on requester 1 that must leave rdata alone.
    vec[0] = '{inp(1, 0, 32'h10, 0, 0, 0, 0, 0),          ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vec[1] = '{inp(1, 0, 32'h10, 0, 0, 0, 0, 0),          ex(0, 0, 0, 1, 1, 0, 32'h10, 0, 0)};
    vec[2] = '{inp(1, 0, 32'h10, 0, 0, 0, 0, 0),          ex(0, 0, 0, 1, 0, 0, 32'h10, 0, 0)};
    vec[3] = '{inp(0, 0, 32'h10, 0, 0, 0, 0, 0),          ex(1, 0, 0, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF)};
    vec[4] = '{inp(0, 0, 0, 0, 1, 1, 32'h20, 32'h55),     ex(0, 0, 0, 0, 0, 0, 32'h10, 0, 32'hDEADBEEF)};
    vec[5] = '{inp(0, 0, 0, 0, 1, 1, 32'h20, 32'h55),     ex(0, 0, 1, 1, 1, 1, 32'h20, 32'h55, 32'hDEADBEEF)};
    vec[6] = '{inp(0, 0, 0, 0, 1, 1, 32'h20, 32'h55),     ex(0, 0, 1, 1, 0, 0, 32'h20, 32'h55, 32'hDEADBEEF)};
    vec[7] = '{inp(0, 0, 0, 0, 0, 1, 32'h20, 32'h55),     ex(0, 1, 1, 1, 0, 0, 32'h20, 32'h55, 32'hDEADBEEF)};
    vec[8] = '{inp(0, 0, 0, 0, 0, 0, 0, 0),               ex(0, 0, 1, 0, 0, 0, 32'h20, 32'h55, 32'hDEADBEEF)};

    clear_inputs();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("vec%0d", i), 128'(cur1()), 128'(vec[i].e));
      {req0, we0, addr0, wdata0, req1, we1, addr1, wdata1} = vec[i].i;
      @(negedge clk);
    end

    // Both requesters held for four transactions: 0 wins first, then strict alternation.
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      logic exp_a0, exp_a1, exp_busy, exp_sel;
      exp_a0   = (c == 3) || (c == 11);
      exp_a1   = (c == 7) || (c == 15);
      exp_busy = (c % 4) != 0;
      exp_sel  = (c == 0) ? 1'b0 : 1'(((c - 1) / 4) % 2);
      check($sformatf("rr_c%0d", c), 128'({ack0, ack1, busy, sel}),
            128'({exp_a0, exp_a1, exp_busy, exp_sel}));
      if (exp_a0) check($sformatf("rr_rdata0_c%0d", c), 128'(rdata), 128'(32'hDEADBEEF));
      if (exp_a1) check($sformatf("rr_rdata1_c%0d", c), 128'(rdata), 128'(32'h55));
      if (c == 0) begin
        req0 = 1'b1; addr0 = 32'h10;
        req1 = 1'b1; addr1 = 32'h20;
      end
      if (c == 15) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
    end

    // Reset during WAIT aborts the access; the held request is granted again afterwards.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      req0 = 1'b1; addr0 = 32'h10;
      @(negedge clk);
    end
    check("abort_wait_busy", 128'({busy, mem_en, ack0}), 128'(3'b100));
    rst = 1'b1;
    #1;
    check("abort_outputs_zero", 128'(cur1()), 128'(outs_t'(0)));
    @(negedge clk);
    check("abort_no_ack", 128'({ack0, ack1, busy}), 128'(3'b000));
    rst = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      check($sformatf("regrant_c%0d", c), 128'({ack0, ack1, busy, mem_en, rdata}),
            128'({c == 3, 1'b0, (c >= 1) && (c <= 3), c == 1,
                  (c >= 3) ? 32'hDEADBEEF : 32'h0}));
      if (c == 3) req0 = 1'b0;
      @(negedge clk);
    end

    // MEM_LAT = 3: the address input changes mid-WAIT and must not reach the memory.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      check($sformatf("lat3_c%0d", c), 128'({ack0_b, ack1_b, busy_b, mem_en_b, mem_addr_b, rdata_b}),
            128'({c == 5, 1'b0, (c >= 1) && (c <= 5), c == 1,
                  (c == 0) ? 32'h0 : 32'h10, (c >= 5) ? 32'hDEADBEEF : 32'h0}));
      if (c == 0) begin req0_b = 1'b1; addr0_b = 32'h10; end
      if (c == 2) addr0_b = 32'h99;
      if (c == 5) req0_b = 1'b0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary line");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-port memory between two requesters, e.g. instruction fetch and data load/store in the lab processor. It latches the winning request and drives the select line of the 2:1 address/data muxes in front of the memory. It issues one access, waits a fixed memory latency, then returns read data with a one-cycle acknowledge.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
MEM_LAT, 1, memory read latency in cycles. Legal range 1..15; a 4-bit wait counter is used.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req0  input  1  request from requester 0; held high until ack0.
we0  input  1  requester 0 write enable (1 = write, 0 = read).
addr0  input  ADDR_W  requester 0 address.
wdata0  input  DATA_W  requester 0 write data.
req1  input  1  request from requester 1.
we1  input  1  requester 1 write enable.
addr1  input  ADDR_W  requester 1 address.
wdata1  input  DATA_W  requester 1 write data.
ack0  output  1  one-cycle completion pulse to requester 0.
ack1  output  1  one-cycle completion pulse to requester 1.
rdata  output  DATA_W  read data, valid while ack0 or ack1 is high after a read.
sel  output  1  granted requester index; drives the 2:1 mux select.
busy  output  1  high while a transaction is in flight.
mem_en  output  1  memory access strobe.
mem_we  output  1  memory write strobe.
mem_addr  output  ADDR_W  latched memory address.
mem_wdata  output  DATA_W  latched memory write data.
mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset (async, active-high) forces every output to 0 immediately: ack0, ack1, rdata, sel, busy, mem_en, mem_we, mem_addr, mem_wdata. It also sets state=IDLE, wait counter=0 and last_grant=1, so requester 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Only one reqN high: grant N.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch addrN/wdataN/weN into mem_addr/mem_wdata/a we register; set sel=N and last_grant=N; go to ISSUE.
- ISSUE: exactly one cycle. mem_en=1 and mem_we=latched we. Load counter=MEM_LAT-1. Go to WAIT.
- WAIT: lasts MEM_LAT cycles, with mem_en=0 and mem_we=0.
  - Counter decrements each cycle.
  - In the cycle where the counter is 0: if the access is a read, capture mem_rdata into rdata; then go to RESP.
  - For a write, rdata keeps its previous value.
- RESP: exactly one cycle with ackN=1 for the granted N. Then go to IDLE.
- Latency: a request sampled at the end of cycle 0 gives ISSUE in cycle 1 and the ack in cycle 2+MEM_LAT.
  - For back-to-back transactions, the IDLE cycle between RESP and the next ISSUE is mandatory.
- busy=1 in ISSUE, WAIT and RESP; busy=0 in IDLE.
- sel holds the granted index from grant through RESP and retains that value in IDLE.
- mem_addr/mem_wdata hold their latched values until the next grant. Input changes after grant are ignored.
- A reqN dropped mid-transaction is ignored: the access completes and ackN still pulses.
- A reqN still high in the IDLE cycle after its ack is treated as a new request and arbitrated normally.
- Starvation bound: while both requesters hold their requests, grants strictly alternate. A waiting requester waits at most one transaction.
- ack0 and ack1 are never high in the same cycle.
- Reset mid-transaction aborts the access: no ack is produced and any pending request is re-arbitrated after reset is released.

Test Plan:
1. MEM_LAT=1; req0 read, addr0=0x10; memory model returns 0xDEADBEEF. Required: mem_en high in cycle 1 only with mem_addr=0x10; ack0 in cycle 3 with rdata=0xDEADBEEF; ack1 never asserts.
2. req0 and req1 both raised in the same cycle right after reset. Required: requester 0 is granted first (sel=0, ack0), then requester 1 (sel=1, ack1), with one IDLE cycle between the transactions.
3. Both requests held continuously for 4 transactions. Required: grant order is 0,1,0,1; ack pulses alternate; busy drops for exactly one cycle between transactions.
4. req1 write, addr1=0x20, wdata1=0x55, with rdata previously 0xDEADBEEF. Required: mem_we=1 and mem_en=1 only in the ISSUE cycle, with mem_wdata=0x55; ack1 in cycle 3; rdata stays 0xDEADBEEF.
5. MEM_LAT=3; req0 read; addr0 changed to 0x99 during WAIT. Required: mem_addr stays at the original address; ack0 in cycle 5.
6. rst pulsed during WAIT with req0 held. Required: all outputs 0 immediately and no ack; after reset release, req0 is re-granted and completes normally.
